// File: rtl/multicore_pkg.sv
// Shared constants and result record for the multicore result collection path.
// The result record tags every data word with the index of the core that produced it.
package multicore_pkg;

    localparam int N_CORES    = 27;
    localparam int DATA_W     = 31;
    localparam int FIFO_DEPTH = 16;
    localparam int CORE_IDX_W = $clog2(N_CORES);
    localparam int DROP_W     = 16;

    typedef struct packed {
        logic [CORE_IDX_W-1:0]    core;
        logic signed [DATA_W-1:0] data;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

    // Next core index in round-robin order, wrapping after the last core.
    function automatic logic [CORE_IDX_W-1:0] next_core(input logic [CORE_IDX_W-1:0] idx);
        if (idx == CORE_IDX_W'(N_CORES - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is always visible on pop_data.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/multicore_out_collector.sv
// Captures per-core result strobes into holding registers and merges them, round-robin,
// into a single core-tagged valid/ready result stream through a FWFT FIFO.
module multicore_out_collector
    import multicore_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CORES*DATA_W-1:0]   io_out,
    input  logic [N_CORES-1:0]          out_en,
    output logic [DATA_W-1:0]           res_data,
    output logic [CORE_IDX_W-1:0]       res_core,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        overflow,
    output logic [DROP_W-1:0]           drop_cnt
);

    logic [DATA_W-1:0]      hold_data [N_CORES];
    logic [N_CORES-1:0]     pend;
    logic [CORE_IDX_W-1:0]  last;

    logic [CORE_IDX_W-1:0]  cand;
    logic                   grant_found;
    logic [CORE_IDX_W-1:0]  grant_idx;
    logic                   grant;
    logic [N_CORES-1:0]     grant_vec;
    logic [N_CORES-1:0]     drop;
    logic [N_CORES-1:0]     load;
    logic [CORE_IDX_W:0]    drop_num;
    logic [DROP_W:0]        drop_sum;

    result_t                push_word;
    result_t                head_word;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                   unused_fifo_count;

    // Search pend starting just after the last granted core; fullness gates the grant.
    always_comb begin
        cand        = last;
        grant_found = 1'b0;
        grant_idx   = last;
        for (int k = 0; k < N_CORES; k++) begin
            cand = next_core(cand);
            if (!grant_found && pend[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant = grant_found && !fifo_full;

    // A strobe on a still-pending core is lost unless that core is drained this very cycle.
    always_comb begin
        grant_vec = '0;
        drop      = '0;
        load      = '0;
        drop_num  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            grant_vec[i] = grant && (grant_idx == CORE_IDX_W'(i));
            drop[i]      = out_en[i] && pend[i] && !grant_vec[i];
            load[i]      = out_en[i] && !drop[i];
            drop_num     = drop_num + (CORE_IDX_W+1)'(drop[i]);
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(drop_num);

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CORES; i++) begin
            if (load[i]) begin
                hold_data[i] <= io_out[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            last     <= CORE_IDX_W'(N_CORES - 1);
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            pend <= (pend & ~grant_vec) | load;
            if (grant) begin
                last <= grant_idx;
            end
            if (|drop) begin
                overflow <= 1'b1;
            end
            drop_cnt <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
        end
    end

    always_comb begin
        push_word      = '0;
        push_word.core = grant_idx;
        push_word.data = hold_data[grant_idx];
    end

    assign pop = res_valid && res_ready;

    sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign unused_fifo_count = ^fifo_count;

    assign res_valid = !fifo_empty;
    assign res_data  = head_word.data;
    assign res_core  = head_word.core;

endmodule

// File: tb/tb_multicore_out_collector.sv
// Self-checking bench for multicore_out_collector: table vectors, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_multicore_out_collector;
    import multicore_pkg::*;

    localparam int NC   = N_CORES;
    localparam int W    = DATA_W;
    localparam int IO_W = NC * W;

    typedef struct {
        int         core;
        logic [W-1:0] data;
    } rec_t;

    typedef struct {
        int           core;
        logic [W-1:0] data;
        logic         rdy;
        logic         exp_valid;
        int           exp_core;
        logic [W-1:0] exp_data;
        int           exp_drops;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [IO_W-1:0]       io;
    logic [NC-1:0]         en;
    logic                  ready;
    logic [W-1:0]          res_data;
    logic [CORE_IDX_W-1:0] res_core;
    logic                  res_valid;
    logic                  overflow;
    logic [15:0]           drop_cnt;

    int errors = 0;
    int checks = 0;

    bit           m_pend [NC];
    logic [W-1:0] m_hold [NC];
    int           m_last;
    rec_t         m_q[$];
    int           m_drops;
    bit           m_ovf;

    rec_t got_q[$];
    rec_t exp_q[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    multicore_out_collector dut (
        .clk       (clk),
        .rst       (rst),
        .io_out    (io),
        .out_en    (en),
        .res_data  (res_data),
        .res_core  (res_core),
        .res_valid (res_valid),
        .res_ready (ready),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    function automatic logic [IO_W-1:0] put(input logic [IO_W-1:0] v, input int c, input logic [W-1:0] d);
        logic [IO_W-1:0] mask;
        logic [IO_W-1:0] val;
        mask = {{(IO_W-W){1'b0}}, {W{1'b1}}} << (c * W);
        val  = {{(IO_W-W){1'b0}}, d} << (c * W);
        return (v & ~mask) | val;
    endfunction

    function automatic logic [W-1:0] get(input logic [IO_W-1:0] v, input int c);
        logic [IO_W-1:0] s;
        s = v >> (c * W);
        return s[W-1:0];
    endfunction

    function automatic logic [NC-1:0] onehot(input int c);
        logic [NC-1:0] one;
        one = {{(NC-1){1'b0}}, 1'b1};
        if (c < 0) begin
            return '0;
        end
        return one << c;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_pend[c] = 1'b0;
        end
        m_last  = NC - 1;
        m_q.delete();
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    // One clock edge of the block described in plain terms: pick the next waiting core
    // after the previous winner if the queue has room, pop the head, then capture strobes.
    task automatic model_step();
        int   g;
        int   c;
        bit   full;
        bit   e;
        rec_t r;
        g    = -1;
        full = (m_q.size() >= FIFO_DEPTH);
        if (!full) begin
            for (int k = 1; k <= NC; k++) begin
                c = (m_last + k) % NC;
                if (g < 0 && m_pend[c]) begin
                    g = c;
                end
            end
        end
        if (m_q.size() > 0 && ready) begin
            void'(m_q.pop_front());
        end
        if (g >= 0) begin
            r.core = g;
            r.data = m_hold[g];
            m_q.push_back(r);
            m_last = g;
        end
        for (int i = 0; i < NC; i++) begin
            e = en[i];
            if (e) begin
                if (m_pend[i] && i != g) begin
                    if (m_drops < 65535) begin
                        m_drops++;
                    end
                    m_ovf = 1'b1;
                end else begin
                    m_hold[i] = get(io, i);
                    m_pend[i] = 1'b1;
                end
            end else if (i == g) begin
                m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NC-1:0] en_v, input logic [IO_W-1:0] io_v, input logic rdy_v);
        en    = en_v;
        io    = io_v;
        ready = rdy_v;
        @(posedge clk);
        if (!rst) begin
            model_step();
        end
        #1;
    endtask

    task automatic reset_assert();
        rst = 1'b1;
        en  = '0;
        model_reset();
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_reset();
        reset_assert();
        reset_release();
    endtask

    task automatic drain(input int total, input int budget);
        int   n;
        rec_t r;
        n = 0;
        while (got_q.size() < total && n < budget) begin
            if (res_valid) begin
                r.core = int'(res_core);
                r.data = res_data;
                got_q.push_back(r);
            end
            applyStimulus('0, io, 1'b1);
            n++;
        end
        checkOutput("drain_count", 64'(got_q.size()), 64'(total));
    endtask

    task automatic compare_queues(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checkOutput($sformatf("%s_core%0d", tag, i), 64'(got_q[i].core), 64'(exp_q[i].core));
                checkOutput($sformatf("%s_data%0d", tag, i), 64'(got_q[i].data), 64'(exp_q[i].data));
            end
        end
    endtask

    task automatic compare_model(input string tag);
        checkOutput({tag, "_valid"}, 64'(res_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            checkOutput({tag, "_core"}, 64'(res_core), 64'(m_q[0].core));
            checkOutput({tag, "_data"}, 64'(res_data), 64'(m_q[0].data));
        end
        checkOutput({tag, "_drops"}, 64'(drop_cnt), 64'(m_drops));
        checkOutput({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    endtask

    initial begin
        logic [IO_W-1:0] io_v;
        logic [NC-1:0]   en_v;
        rec_t            r;

        rst   = 1'b1;
        en    = '0;
        io    = '0;
        ready = 1'b0;

        // core, data, ready, exp_valid, exp_core, exp_data, exp_drops
        vecs[0]  = '{5,  31'(-12345), 1'b1, 1'b0, 0, 31'd0,         0};
        vecs[1]  = '{-1, 31'd0,       1'b1, 1'b1, 5, 31'(-12345),   0};
        vecs[2]  = '{-1, 31'd0,       1'b1, 1'b0, 0, 31'd0,         0};
        vecs[3]  = '{7,  31'd111,     1'b1, 1'b0, 0, 31'd0,         0};
        vecs[4]  = '{7,  31'd222,     1'b1, 1'b1, 7, 31'd111,       0};
        vecs[5]  = '{-1, 31'd0,       1'b1, 1'b1, 7, 31'd222,       0};
        vecs[6]  = '{-1, 31'd0,       1'b1, 1'b0, 0, 31'd0,         0};
        vecs[7]  = '{9,  31'd9,       1'b0, 1'b0, 0, 31'd0,         0};
        vecs[8]  = '{-1, 31'd0,       1'b0, 1'b1, 9, 31'd9,         0};
        vecs[9]  = '{-1, 31'd0,       1'b0, 1'b1, 9, 31'd9,         0};
        vecs[10] = '{-1, 31'd0,       1'b1, 1'b0, 0, 31'd0,         0};

        do_reset();
        checkOutput("reset_valid", 64'(res_valid), 64'd0);
        checkOutput("reset_ovf",   64'(overflow),  64'd0);
        checkOutput("reset_drops", 64'(drop_cnt),  64'd0);

        for (int i = 0; i < 11; i++) begin
            io_v = put('0, (vecs[i].core < 0) ? 0 : vecs[i].core, vecs[i].data);
            applyStimulus(onehot(vecs[i].core), io_v, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_valid", i), 64'(res_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_core", i), 64'(res_core), 64'(vecs[i].exp_core));
                checkOutput($sformatf("vec%0d_data", i), 64'(res_data), 64'(vecs[i].exp_data));
            end
            checkOutput($sformatf("vec%0d_drops", i), 64'(drop_cnt), 64'(vecs[i].exp_drops));
        end

        $display("[TB] all cores at once");
        do_reset();
        io_v = '0;
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < NC; c++) begin
            io_v   = put(io_v, c, W'(c * 100));
            r.core = c;
            r.data = W'(c * 100);
            exp_q.push_back(r);
        end
        applyStimulus({NC{1'b1}}, io_v, 1'b1);
        drain(NC, 60);
        compare_queues("allcores");
        checkOutput("allcores_ovf",   64'(overflow),  64'd0);
        checkOutput("allcores_empty", 64'(res_valid), 64'd0);

        $display("[TB] round-robin fairness");
        do_reset();
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 12; i++) begin
            r.core = (i % 2 == 0) ? 3 : 20;
            r.data = W'(((i % 2 == 0) ? 3000 : 20000) + i / 2);
            exp_q.push_back(r);
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (res_valid) begin
                r.core = int'(res_core);
                r.data = res_data;
                got_q.push_back(r);
            end
            io_v = put(put('0, 3, W'(3000 + cyc / 2)), 20, W'(20000 + cyc / 2));
            en_v = (cyc % 2 == 0) ? (onehot(3) | onehot(20)) : '0;
            applyStimulus(en_v, io_v, 1'b1);
        end
        drain(12, 30);
        compare_queues("rr");
        checkOutput("rr_drops", 64'(drop_cnt), 64'd0);
        checkOutput("rr_ovf",   64'(overflow), 64'd0);

        $display("[TB] backpressure drop");
        do_reset();
        exp_q.delete();
        got_q.delete();
        io_v = '0;
        for (int c = 0; c < NC; c++) begin
            io_v = put(io_v, c, W'(500 + c));
        end
        applyStimulus({NC{1'b1}}, io_v, 1'b0);
        repeat (17) applyStimulus('0, io_v, 1'b0);
        checkOutput("bp_head_valid", 64'(res_valid), 64'd1);
        checkOutput("bp_head_core",  64'(res_core),  64'd0);
        applyStimulus(onehot(0), put(io_v, 0, W'(7000)), 1'b0);
        checkOutput("bp_held_drops", 64'(drop_cnt), 64'd0);
        checkOutput("bp_held_ovf",   64'(overflow), 64'd0);
        applyStimulus(onehot(0), put(io_v, 0, W'(8000)), 1'b0);
        checkOutput("bp_drop_drops", 64'(drop_cnt), 64'd1);
        checkOutput("bp_drop_ovf",   64'(overflow), 64'd1);
        for (int c = 0; c < NC; c++) begin
            r.core = c;
            r.data = W'(500 + c);
            exp_q.push_back(r);
        end
        r.core = 0;
        r.data = W'(7000);
        exp_q.push_back(r);
        drain(NC + 1, 100);
        compare_queues("bp");
        checkOutput("bp_end_ovf",   64'(overflow),  64'd1);
        checkOutput("bp_end_drops", 64'(drop_cnt),  64'd1);
        checkOutput("bp_end_empty", 64'(res_valid), 64'd0);

        $display("[TB] reset mid-operation");
        do_reset();
        io_v = '0;
        for (int c = 0; c < NC; c++) begin
            io_v = put(io_v, c, W'(900 + c));
        end
        applyStimulus({NC{1'b1}}, io_v, 1'b0);
        applyStimulus(onehot(20), io_v, 1'b0);
        repeat (9) applyStimulus('0, io_v, 1'b0);
        checkOutput("mid_pre_valid", 64'(res_valid), 64'd1);
        checkOutput("mid_pre_drops", 64'(drop_cnt),  64'd1);
        #3;
        reset_assert();
        #1;
        checkOutput("mid_rst_valid", 64'(res_valid), 64'd0);
        checkOutput("mid_rst_drops", 64'(drop_cnt),  64'd0);
        checkOutput("mid_rst_ovf",   64'(overflow),  64'd0);
        reset_release();
        exp_q.delete();
        got_q.delete();
        r.core = 0;
        r.data = W'(42);
        exp_q.push_back(r);
        r.core = 26;
        r.data = W'(2626);
        exp_q.push_back(r);
        applyStimulus(onehot(0) | onehot(26), put(put('0, 0, W'(42)), 26, W'(2626)), 1'b1);
        drain(2, 20);
        compare_queues("mid_after");

        $display("[TB] randomized traffic");
        do_reset();
        for (int phase = 0; phase < 2; phase++) begin
            for (int cyc = 0; cyc < 250; cyc++) begin
                io_v = '0;
                en_v = '0;
                for (int c = 0; c < NC; c++) begin
                    io_v = put(io_v, c, W'($urandom));
                    if ($urandom_range(0, 99) < ((phase == 0) ? 3 : 10)) begin
                        en_v = en_v | onehot(c);
                    end
                end
                applyStimulus(en_v, io_v, ($urandom_range(0, 99) < ((phase == 0) ? 80 : 40)) ? 1'b1 : 1'b0);
                compare_model("rand");
            end
        end
        for (int cyc = 0; cyc < 80; cyc++) begin
            applyStimulus('0, io, 1'b1);
            compare_model("rand_drain");
        end
        checkOutput("rand_empty", 64'(res_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
